// File: rtl/fpnew_sdotp_result_buffer.sv
// In-order result FIFO behind the sdotp multi-format wrapper.
// Registered-only ready/valid with sticky exception-flag accrual.
module fpnew_sdotp_result_buffer #(
  parameter int unsigned LaneWidth = 64,
  parameter int unsigned Depth     = 4,
  parameter type         TagType   = logic,
  parameter type         AuxType   = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [LaneWidth-1:0]     in_result_i,
  input  logic [4:0]               in_status_i,
  input  logic                     in_ext_bit_i,
  input  TagType                   in_tag_i,
  input  AuxType                   in_aux_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [LaneWidth-1:0]     out_result_o,
  output logic [4:0]               out_status_o,
  output logic                     out_ext_bit_o,
  output TagType                   out_tag_o,
  output AuxType                   out_aux_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [4:0]               fflags_o,
  input  logic                     fflags_clr_i,
  output logic [$clog2(Depth):0]   usage_o,
  output logic                     busy_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned UW = AW + 1;
  localparam logic [UW-1:0] FULL = UW'(Depth);

  logic [LaneWidth-1:0] r_res [Depth];
  logic [4:0]           r_sts [Depth];
  logic                 r_ext [Depth];
  TagType               r_tag [Depth];
  AuxType               r_aux [Depth];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [UW-1:0] r_usage;
  logic [4:0]    r_fflags;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [UW-1:0] w_usage_nxt;
  logic [4:0]    w_fflags_nxt;

  // Full/empty come from the occupancy count, so equal pointers are never ambiguous.
  assign w_full  = (r_usage == FULL);
  assign w_empty = (r_usage == '0);

  assign in_ready_o  = ~w_full;
  assign out_valid_o = ~w_empty;
  assign busy_o      = ~w_empty;
  assign usage_o     = r_usage;
  assign fflags_o    = r_fflags;

  assign w_push = in_valid_i & ~w_full & ~flush_i;
  assign w_pop  = out_ready_i & ~w_empty & ~flush_i;

  assign out_result_o  = r_res[r_rptr];
  assign out_status_o  = r_sts[r_rptr];
  assign out_ext_bit_o = r_ext[r_rptr];
  assign out_tag_o     = r_tag[r_rptr];
  assign out_aux_o     = r_aux[r_rptr];

  always_comb begin
    w_usage_nxt = r_usage;
    unique case ({w_push, w_pop})
      2'b10:   w_usage_nxt = r_usage + UW'(1);
      2'b01:   w_usage_nxt = r_usage - UW'(1);
      default: w_usage_nxt = r_usage;
    endcase
  end

  // A clear still keeps whatever flags are popped in the same cycle.
  always_comb begin
    w_fflags_nxt = r_fflags;
    if (fflags_clr_i) begin
      w_fflags_nxt = w_pop ? out_status_o : 5'b0;
    end else if (w_pop) begin
      w_fflags_nxt = r_fflags | out_status_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_usage  <= '0;
      r_fflags <= '0;
    end else begin
      r_fflags <= w_fflags_nxt;
      if (flush_i) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_usage <= '0;
      end else begin
        r_usage <= w_usage_nxt;
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_res[i] <= '0;
        r_sts[i] <= '0;
        r_ext[i] <= 1'b0;
        r_tag[i] <= '0;
        r_aux[i] <= '0;
      end
    end else if (w_push) begin
      r_res[r_wptr] <= in_result_i;
      r_sts[r_wptr] <= in_status_i;
      r_ext[r_wptr] <= in_ext_bit_i;
      r_tag[r_wptr] <= in_tag_i;
      r_aux[r_wptr] <= in_aux_i;
    end
  end

endmodule

// File: tb/tb_fpnew_sdotp_result_buffer.sv
// Directed bench for the sdotp result buffer.
// Inputs change and outputs are sampled on the falling edge.
module tb_fpnew_sdotp_result_buffer;

  typedef logic [3:0] tag_t;
  typedef logic [1:0] aux_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        flush_i = 1'b0;
  logic [63:0] in_result_i = '0;
  logic [4:0]  in_status_i = '0;
  logic        in_ext_bit_i = 1'b0;
  tag_t        in_tag_i = '0;
  aux_t        in_aux_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] out_result_o;
  logic [4:0]  out_status_o;
  logic        out_ext_bit_o;
  tag_t        out_tag_o;
  aux_t        out_aux_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i = 1'b0;
  logic [2:0]  usage_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  fpnew_sdotp_result_buffer #(
    .LaneWidth(64),
    .Depth    (4),
    .TagType  (tag_t),
    .AuxType  (aux_t)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .in_result_i  (in_result_i),
    .in_status_i  (in_status_i),
    .in_ext_bit_i (in_ext_bit_i),
    .in_tag_i     (in_tag_i),
    .in_aux_i     (in_aux_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .out_result_o (out_result_o),
    .out_status_o (out_status_o),
    .out_ext_bit_o(out_ext_bit_o),
    .out_tag_o    (out_tag_o),
    .out_aux_o    (out_aux_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .fflags_o     (fflags_o),
    .fflags_clr_i (fflags_clr_i),
    .usage_o      (usage_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int got;
    int mx;

    // asynchronous reset state
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_usage", 64'(usage_o), 0);
    chk("rst_ready", 64'(in_ready_o), 1);
    chk("rst_valid", 64'(out_valid_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_fflags", 64'(fflags_o), 0);
    chk("rst_result", out_result_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // ordering, one-cycle latency
    in_valid_i = 1'b1; in_result_i = 64'h1; in_tag_i = 4'd1; out_ready_i = 1'b1;
    chk("ord_empty", 64'(out_valid_o), 0);
    @(negedge clk_i);
    chk("ord_v1", 64'(out_valid_o), 1);
    chk("ord_r1", out_result_o, 64'h1);
    chk("ord_t1", 64'(out_tag_o), 1);
    in_result_i = 64'h2; in_tag_i = 4'd2;
    @(negedge clk_i);
    chk("ord_r2", out_result_o, 64'h2);
    chk("ord_t2", 64'(out_tag_o), 2);
    chk("ord_u2", 64'(usage_o), 1);
    in_result_i = 64'h3; in_tag_i = 4'd3;
    @(negedge clk_i);
    chk("ord_r3", out_result_o, 64'h3);
    chk("ord_t3", 64'(out_tag_o), 3);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("ord_drain", 64'(usage_o), 0);
    chk("ord_busy", 64'(busy_o), 0);

    // full and backpressure
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1; in_result_i = 64'h10 + 64'(i);
      @(negedge clk_i);
    end
    chk("full_usage", 64'(usage_o), 4);
    chk("full_ready", 64'(in_ready_o), 0);
    in_result_i = 64'h14;
    @(negedge clk_i);
    chk("full_hold", 64'(usage_o), 4);
    chk("full_head", out_result_o, 64'h10);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_ready", 64'(in_ready_o), 1);
    chk("bp_usage", 64'(usage_o), 3);
    chk("bp_head", out_result_o, 64'h11);
    out_ready_i = 1'b0;
    @(negedge clk_i);
    chk("bp_refill", 64'(usage_o), 4);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    for (int j = 1; j < 5; j++) begin
      chk("bp_order", out_result_o, 64'h10 + 64'(j));
      @(negedge clk_i);
    end
    chk("bp_empty", 64'(usage_o), 0);

    // wrap-around with concurrent push and pop
    got = 0; mx = 0;
    for (int i = 0; i < 11; i++) begin
      in_valid_i = (i < 10);
      in_result_i = 64'h100 + 64'(i);
      if (out_valid_o) begin
        chk("wrap_order", out_result_o, 64'h100 + 64'(got));
        got++;
      end
      if (int'(usage_o) > mx) mx = int'(usage_o);
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    chk("wrap_count", 64'(got), 10);
    chk("wrap_max_le2", 64'(mx <= 2), 1);
    chk("wrap_empty", 64'(usage_o), 0);

    // exception flag accrual and clear
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_result_i = 64'h21; in_status_i = 5'b00001;
    @(negedge clk_i);
    in_result_i = 64'h22; in_status_i = 5'b10000;
    @(negedge clk_i);
    in_result_i = 64'h23; in_status_i = 5'b00100;
    @(negedge clk_i);
    in_valid_i = 1'b0; in_status_i = 5'b0; out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("flg_first", 64'(fflags_o), 64'b00001);
    @(negedge clk_i);
    chk("flg_accum", 64'(fflags_o), 64'b10001);
    fflags_clr_i = 1'b1;
    @(negedge clk_i);
    fflags_clr_i = 1'b0; out_ready_i = 1'b0;
    chk("flg_clr_pop", 64'(fflags_o), 64'b00100);
    chk("flg_empty", 64'(usage_o), 0);

    // flush discards same-cycle push and pop
    in_valid_i = 1'b1; in_status_i = 5'b01000;
    for (int i = 0; i < 3; i++) begin
      in_result_i = 64'h30 + 64'(i);
      @(negedge clk_i);
    end
    in_result_i = 64'h33; flush_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_status_i = 5'b0;
    chk("fl_usage", 64'(usage_o), 0);
    chk("fl_valid", 64'(out_valid_o), 0);
    chk("fl_fflags", 64'(fflags_o), 64'b00100);
    in_valid_i = 1'b1; in_result_i = 64'h44;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk("fl_next_v", 64'(out_valid_o), 1);
    chk("fl_next_r", out_result_o, 64'h44);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("fl_next_pop", 64'(usage_o), 0);
    out_ready_i = 1'b0; fflags_clr_i = 1'b1;
    @(negedge clk_i);
    fflags_clr_i = 1'b0;
    chk("clr_idle", 64'(fflags_o), 0);

    // reset mid-operation
    in_valid_i = 1'b1; in_status_i = 5'b00010;
    for (int i = 0; i < 3; i++) begin
      in_result_i = 64'h50 + 64'(i);
      @(negedge clk_i);
    end
    in_valid_i = 1'b0; in_status_i = 5'b0; out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    chk("mr_pre_fflags", 64'(fflags_o), 64'b00010);
    chk("mr_pre_usage", 64'(usage_o), 2);
    #2 rst_ni = 1'b0;
    #1;
    chk("mr_valid", 64'(out_valid_o), 0);
    chk("mr_usage", 64'(usage_o), 0);
    chk("mr_fflags", 64'(fflags_o), 0);
    chk("mr_ready", 64'(in_ready_o), 1);
    chk("mr_result", out_result_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    in_valid_i = 1'b1; in_result_i = 64'h66;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk("mr_post_v", 64'(out_valid_o), 1);
    chk("mr_post_r", out_result_o, 64'h66);
    chk("mr_post_u", 64'(usage_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
